// File: rtl/semaforo_n.sv
// semaforo_n: N-approach round-robin traffic-light controller.
// One approach at a time gets green, then yellow, then an all-red clearance.
// Per-approach buttons latch requests that can cut a green short (after the
// minimum green) and steer the next grant. A night mode flashes all yellows.
module semaforo_n #(
  parameter int N           = 4,
  parameter int W           = 8,
  parameter int T_VERDE     = 12,
  parameter int T_VERDE_MIN = 4,
  parameter int T_AMARELO   = 3,
  parameter int T_VERMELHO  = 2,
  parameter int T_PISCA     = 2,
  localparam int AW         = ($clog2(N) < 1) ? 1 : $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    bt,
  input  logic            pisca,
  output logic [3*N-1:0]  luz,
  output logic [AW-1:0]   ativo,
  output logic [N-1:0]    pend
);

  typedef enum logic [1:0] {
    VERDE    = 2'd0,
    AMARELO  = 2'd1,
    VERMELHO = 2'd2,
    PISCA    = 2'd3
  } estado_t;

  estado_t        state_r, state_n;
  logic [W-1:0]   cnt_r, cnt_n;
  logic [AW-1:0]  ativo_r, ativo_n;
  logic [N-1:0]   pend_r, pend_n;
  logic           fase_r, fase_n;   // flash half: 0 = lamps on, 1 = lamps off

  logic [N-1:0]   onehot_s;
  logic [AW-1:0]  prox_s;
  logic           achou_s;
  logic [AW:0]    soma_s;
  logic           entra_verde_s;

  // Round-robin search for the next approach, starting just after the owner.
  always_comb begin
    onehot_s = N'(1) << ativo_r;
    prox_s   = (ativo_r == AW'(N-1)) ? AW'(0) : ativo_r + AW'(1);
    achou_s  = 1'b0;
    soma_s   = '0;
    for (int k = 1; k < N; k++) begin
      soma_s = {1'b0, ativo_r} + (AW+1)'(k);
      if (soma_s >= (AW+1)'(N)) begin
        soma_s = soma_s - (AW+1)'(N);
      end else begin
        soma_s = soma_s;
      end
      if (!achou_s && pend_r[soma_s[AW-1:0]]) begin
        prox_s  = soma_s[AW-1:0];
        achou_s = 1'b1;
      end else begin
        achou_s = achou_s;
      end
    end
  end

  // Next-state, counter, owner and request-latch logic.
  always_comb begin
    state_n       = state_r;
    cnt_n         = cnt_r + W'(1);
    ativo_n       = ativo_r;
    fase_n        = fase_r;
    entra_verde_s = 1'b0;
    case (state_r)
      VERDE: begin
        // pend_r is the pre-edge value, so a request seen this edge acts next cycle.
        if ((cnt_r == W'(T_VERDE-1)) || pisca ||
            ((cnt_r >= W'(T_VERDE_MIN-1)) && (|(pend_r & ~onehot_s)))) begin
          state_n = AMARELO;
          cnt_n   = '0;
        end else begin
          state_n = VERDE;
        end
      end
      AMARELO: begin
        if (cnt_r == W'(T_AMARELO-1)) begin
          cnt_n   = '0;
          fase_n  = 1'b0;
          state_n = pisca ? PISCA : VERMELHO;
        end else begin
          state_n = AMARELO;
        end
      end
      VERMELHO: begin
        if (cnt_r == W'(T_VERMELHO-1)) begin
          cnt_n = '0;
          if (pisca) begin
            state_n = PISCA;
            fase_n  = 1'b0;
          end else begin
            state_n       = VERDE;
            ativo_n       = prox_s;
            entra_verde_s = 1'b1;
          end
        end else begin
          state_n = VERMELHO;
        end
      end
      PISCA: begin
        if (!pisca) begin
          state_n = VERMELHO;
          cnt_n   = '0;
        end else if (cnt_r == W'(T_PISCA-1)) begin
          cnt_n  = '0;
          fase_n = ~fase_r;
        end else begin
          state_n = PISCA;
        end
      end
      default: begin
        state_n = VERDE;
        cnt_n   = '0;
      end
    endcase

    // The green approach ignores its own button; entering green clears its request.
    pend_n = pend_r;
    for (int i = 0; i < N; i++) begin
      if (bt[i] && !((state_r == VERDE) && (ativo_r == AW'(i)))) begin
        pend_n[i] = 1'b1;
      end else begin
        pend_n[i] = pend_r[i];
      end
      if (entra_verde_s && (ativo_n == AW'(i))) begin
        pend_n[i] = 1'b0;
      end else begin
        pend_n[i] = pend_n[i];
      end
    end
  end

  // State registers with synchronous reset to approach 0 green.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= VERDE;
      cnt_r   <= '0;
      ativo_r <= '0;
      pend_r  <= '0;
      fase_r  <= 1'b0;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
      ativo_r <= ativo_n;
      pend_r  <= pend_n;
      fase_r  <= fase_n;
    end
  end

  // Lamp decode from registered state only; {red, yellow, green} per approach.
  always_comb begin
    luz = '0;
    for (int i = 0; i < N; i++) begin
      case (state_r)
        VERDE:    luz[3*i +: 3] = (ativo_r == AW'(i)) ? 3'b001 : 3'b100;
        AMARELO:  luz[3*i +: 3] = (ativo_r == AW'(i)) ? 3'b010 : 3'b100;
        VERMELHO: luz[3*i +: 3] = 3'b100;
        PISCA:    luz[3*i +: 3] = fase_r ? 3'b000 : 3'b010;
        default:  luz[3*i +: 3] = 3'b100;
      endcase
    end
  end

  assign ativo = ativo_r;
  assign pend  = pend_r;

endmodule

// File: doc/semaforo_n.md
# semaforo_n

Parametrised N-approach traffic-light controller; successor to the two-approach `semaforo` block. Grants right of way to one approach at a time in round-robin order, with per-approach request buttons, an all-red clearance interval and a flashing-yellow night mode. Phase durations and the approach count are set by parameters. It sits between the intersection's button/mode inputs and the lamp drivers.

## Interface
- `N`, 4: number of approaches, 2..8
- `W`, 8: phase counter width
- `T_VERDE`, 12: nominal green length in cycles, 1..2^W-1
- `T_VERDE_MIN`, 4: minimum green before a request may truncate it, 1..T_VERDE
- `T_AMARELO`, 3: yellow length in cycles, 1..2^W-1
- `T_VERMELHO`, 2: all-red clearance length in cycles, 1..2^W-1
- `T_PISCA`, 2: flash half-period in cycles, 1..2^W-1
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `bt`  in  N  request button per approach, level-sampled each edge
- `pisca`  in  1  flash (night) mode request
- `luz`  out  3*N  lamps; approach i at `luz[3i+2:3i]` = {red, yellow, green}
- `ativo`  out  max(1,clog2(N))  index of the approach that owns (or last owned) right of way
- `pend`  out  N  latched pending requests

## Operation
- States: VERDE, AMARELO, VERMELHO (all-red), PISCA. A single up-counter `cnt` is zeroed on every state entry.
- Reset (`rst`=1 at an edge, highest priority): state VERDE, `ativo`=0, `cnt`=0, `pend`=0. Approach 0 shows green (001); all others show red (100).
- Lamp outputs are a pure function of the registered state:
  - VERDE: approach `ativo` = 001.
  - AMARELO: approach `ativo` = 010.
  - All other approaches in VERDE and AMARELO = 100.
  - VERMELHO: all approaches = 100.
  - PISCA: all approaches = 010 in the on half, 000 in the off half.
- Request latch:
  - `pend[i]` is set at an edge where `bt[i]`=1.
  - Exception: `bt[i]` is ignored while approach i is in VERDE.
  - `pend[i]` is cleared at the edge where approach i enters VERDE. Clear wins over a simultaneous set.
  - Requests keep latching during AMARELO, VERMELHO and PISCA.
- VERDE leaves at an edge, to AMARELO, when any of the following holds:
  - `cnt`==T_VERDE-1;
  - `pisca`=1;
  - `cnt`>=T_VERDE_MIN-1 and (`pend` & ~onehot(`ativo`)) != 0. Uses the registered `pend`, before the same-edge update.
- AMARELO: at `cnt`==T_AMARELO-1, goes to PISCA if `pisca`=1, else to VERMELHO.
- VERMELHO:
  - At `cnt`==T_VERMELHO-1 with `pisca`=1: goes to PISCA.
  - Otherwise: goes to VERDE with the new `ativo` set to the next approach.
  - Next approach = first index with `pend` set, searching `ativo`+1, `ativo`+2, ... mod N. If no other request is pending, it is (`ativo`+1) mod N.
- PISCA:
  - Halves alternate every T_PISCA cycles, starting with the on half. `cnt` wraps at T_PISCA-1 and a phase bit toggles.
  - At any edge with `pisca`=0: goes to VERMELHO (full T_VERMELHO), then takes the normal next-approach rule.
- At most one approach is ever non-red in VERDE/AMARELO. There is never a direct VERDE to VERDE transition.
- Counter never exceeds the current phase length. No arithmetic overflow is possible for legal parameters.

## Timing
- Cycle 0 is the first cycle after the reset edge.
- Output latency: lamp, `ativo` and `pend` change in the same cycle as the state update. All are registered state, so there is no combinational input-to-output path.
- `bt` pulse during cycle k: `pend` is visible in cycle k+1. It can first truncate green at the end of cycle max(k+1, T_VERDE_MIN-1).
- Nominal phase lengths are exact: VERDE T_VERDE, AMARELO T_AMARELO, VERMELHO T_VERMELHO cycles. With the defaults, a full unrequested rotation is N*17 = 68 cycles.
- `pisca` is sampled every edge and has priority over requests. It cannot shorten AMARELO or VERMELHO.
- Reset in any state, including PISCA and mid-AMARELO, takes effect at that edge.

## Test plan
- **No requests, defaults:** reset, `bt`=0, `pisca`=0 → approach 0 green cycles 0-11, yellow 12-14, all-red 15-16, approach 1 green from 17; `ativo` 0,1,2,3,0 at cycles 0,17,34,51,68.
- **Truncation with skip:** `bt[2]` high during cycle 1 → `pend`=0100 from cycle 2; yellow cycles 4-6; all-red 7-8; approach 2 green at cycle 9 (approach 1 skipped); `pend`=0000 at cycle 9.
- **Own-button ignore:** `bt[0]` high during cycles 0-5 → `pend` stays 0000; approach 0 green the full 12 cycles.
- **Two requests served in order:** `bt[3]` and `bt[1]` high during cycle 2 →
  - approach 1 green at cycle 9;
  - approach 1 yellow at cycle 13 (min green 4);
  - approach 3 green at cycle 18.
- **Flash mode:** `pisca`=1 from cycle 5 through cycle 19 →
  - yellow cycles 6-8;
  - PISCA from cycle 9: all 010 cycles 9-10, all 000 cycles 11-12, repeating;
  - all-red cycles 21-22;
  - approach 1 green at cycle 23.
- **Reset mid-operation:** `rst`=1 at cycle 13 (approach 0 yellow) with `pend`=0010 → at cycle 14 approach 0 green with `cnt`=0, `pend`=0000, `ativo`=0.
